fw_sram_wishbone_initiator: RTL and testbench

FW_SRAM_WISHBONE_INITIATOR -- requirements
Module: fw_sram_wishbone_initiator

---
 rtl/fw_sram_wishbone_initiator.sv | 160 ++++++++++++++++
 tb/tb_fw_sram_wishbone_initiator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fw_sram_wishbone_initiator.sv
// SRAM-style request port to single-beat Wishbone initiator, with sticky bus-error capture.
// Optional BUS-phase watchdog enabled by defining FW_SRAM_WB_INITIATOR_TIMEOUT_EN.
module fw_sram_wishbone_initiator #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   t_addr,
    input  logic                   t_read_en,
    input  logic                   t_write_en,
    input  logic [DAT_WIDTH/8-1:0] t_byte_en,
    input  logic [DAT_WIDTH-1:0]   t_write_data,
    output logic [DAT_WIDTH-1:0]   t_read_data,
    output logic                   t_read_valid,
    output logic                   t_busy,
    output logic                   t_error,
    output logic [ADR_WIDTH-1:0]   t_error_addr,
    input  logic                   t_error_clr,
    output logic [ADR_WIDTH-1:0]   i_adr,
    output logic [DAT_WIDTH-1:0]   i_dat_w,
    output logic [DAT_WIDTH/8-1:0] i_sel,
    output logic                   i_we,
    output logic                   i_cyc,
    output logic                   i_stb,
    input  logic [DAT_WIDTH-1:0]   i_dat_r,
    input  logic                   i_ack,
    input  logic                   i_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [DAT_WIDTH-1:0]   dat_w_q, dat_w_d;
    logic [DAT_WIDTH/8-1:0] sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   cyc_q, cyc_d;
    logic [DAT_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   error_q, error_d;
    logic [ADR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic                   timeout_hit;
    logic                   bus_err;
    logic                   bus_done;

`ifdef FW_SRAM_WB_INITIATOR_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WD_W-1:0] wdog_q, wdog_d;

    // Compare against TIMEOUT-1 so the bus is held for exactly TIMEOUT cycles.
    assign timeout_hit = (wdog_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE) begin
            wdog_d = '0;
        end else if (state_q == BUS && !bus_done) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus_err  = i_err | (timeout_hit & ~i_ack);
    assign bus_done = i_ack | i_err | timeout_hit;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_w_d    = dat_w_q;
        sel_d      = sel_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        error_d    = error_q & ~t_error_clr;
        err_addr_d = err_addr_q;
        case (state_q)
            IDLE: begin
                if (t_read_en || t_write_en) begin
                    adr_d   = t_addr;
                    we_d    = t_write_en;
                    sel_d   = t_write_en ? t_byte_en : '1;
                    dat_w_d = t_write_en ? t_write_data : '0;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus_done) begin
                    cyc_d   = 1'b0;
                    state_d = RESP;
                    if (!we_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bus_err ? '0 : i_dat_r;
                    end
                    // Setting wins over a same-cycle clear; address only latches the first error.
                    if (bus_err) begin
                        error_d = 1'b1;
                        if (!error_q) begin
                            err_addr_d = adr_q;
                        end
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            dat_w_q    <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_w_q    <= dat_w_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign t_busy       = (state_q != IDLE);
    assign t_read_data  = rdata_q;
    assign t_read_valid = rvalid_q;
    assign t_error      = error_q;
    assign t_error_addr = err_addr_q;
    assign i_adr        = adr_q;
    assign i_dat_w      = dat_w_q;
    assign i_sel        = sel_q;
    assign i_we         = we_q;
    assign i_cyc        = cyc_q;
    assign i_stb        = cyc_q;
endmodule

// File: tb/tb_fw_sram_wishbone_initiator.sv
// Directed self-checking bench for fw_sram_wishbone_initiator (TIMEOUT=4).
// Watchdog expectations follow FW_SRAM_WB_INITIATOR_TIMEOUT_EN as seen by this file.
module tb_fw_sram_wishbone_initiator;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] t_addr;
    logic        t_read_en;
    logic        t_write_en;
    logic [3:0]  t_byte_en;
    logic [31:0] t_write_data;
    logic [31:0] t_read_data;
    logic        t_read_valid;
    logic        t_busy;
    logic        t_error;
    logic [31:0] t_error_addr;
    logic        t_error_clr;
    logic [31:0] i_adr;
    logic [31:0] i_dat_w;
    logic [3:0]  i_sel;
    logic        i_we;
    logic        i_cyc;
    logic        i_stb;
    logic [31:0] i_dat_r;
    logic        i_ack;
    logic        i_err;

    int total = 0;
    int bad   = 0;
    int held;

    fw_sram_wishbone_initiator #(
        .ADR_WIDTH(32),
        .DAT_WIDTH(32),
        .TIMEOUT  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .t_addr      (t_addr),
        .t_read_en   (t_read_en),
        .t_write_en  (t_write_en),
        .t_byte_en   (t_byte_en),
        .t_write_data(t_write_data),
        .t_read_data (t_read_data),
        .t_read_valid(t_read_valid),
        .t_busy      (t_busy),
        .t_error     (t_error),
        .t_error_addr(t_error_addr),
        .t_error_clr (t_error_clr),
        .i_adr       (i_adr),
        .i_dat_w     (i_dat_w),
        .i_sel       (i_sel),
        .i_we        (i_we),
        .i_cyc       (i_cyc),
        .i_stb       (i_stb),
        .i_dat_r     (i_dat_r),
        .i_ack       (i_ack),
        .i_err       (i_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; t_addr = '0; t_read_en = 1'b0; t_write_en = 1'b0;
        t_byte_en = '0; t_write_data = '0; t_error_clr = 1'b0;
        i_dat_r = '0; i_ack = 1'b0; i_err = 1'b0;
        tick(); tick();
        check("rst_busy", t_busy, 0);
        check("rst_cyc", {i_cyc, i_stb, i_we}, 0);
        check("rst_adr", i_adr, 0);
        check("rst_sel_datw", {i_sel, i_dat_w}, 0);
        check("rst_rdata", {t_read_valid, t_read_data}, 0);
        check("rst_err", {t_error, t_error_addr}, 0);

        // Read 0x100, ack in the second BUS cycle; accepted on first edge after reset release
        reset = 1'b1; t_addr = 32'h100; t_read_en = 1'b1;
        tick();
        check("rd_busy1", t_busy, 1);
        check("rd_cyc", {i_cyc, i_stb, i_we}, 3'b110);
        check("rd_adr", i_adr, 32'h100);
        check("rd_sel", i_sel, 4'hF);
        check("rd_datw", i_dat_w, 0);
        t_addr = 32'h999;
        tick();
        check("rd_busy2", t_busy, 1);
        check("rd_hold_adr", i_adr, 32'h100);
        t_read_en = 1'b0; i_ack = 1'b1; i_dat_r = 32'hDEADBEEF;
        tick();
        i_ack = 1'b0; i_dat_r = '0;
        check("rd_busy3", t_busy, 1);
        check("rd_cyc_drop", {i_cyc, i_stb}, 0);
        check("rd_valid", t_read_valid, 1);
        check("rd_data", t_read_data, 32'hDEADBEEF);
        tick();
        check("rd_idle", {t_busy, t_read_valid}, 0);
        check("rd_data_hold", t_read_data, 32'hDEADBEEF);

        // Stray ack in IDLE is ignored
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("idle_ack", {t_busy, t_read_valid, i_cyc}, 0);

        // Write 0x200, immediate ack
        t_addr = 32'h200; t_write_en = 1'b1; t_byte_en = 4'h3; t_write_data = 32'h12345678;
        tick();
        t_write_en = 1'b0; t_byte_en = '0; t_write_data = '0;
        check("wr_cyc", {i_cyc, i_stb, i_we}, 3'b111);
        check("wr_adr", i_adr, 32'h200);
        check("wr_sel", i_sel, 4'h3);
        check("wr_datw", i_dat_w, 32'h12345678);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("wr_resp", {t_busy, i_cyc, t_read_valid}, 3'b100);
        tick();
        check("wr_idle", {t_busy, t_read_valid}, 0);
        check("wr_rdata_hold", t_read_data, 32'hDEADBEEF);

        // Read 0x300 with error (ack also high: error wins)
        t_addr = 32'h300; t_read_en = 1'b1;
        tick();
        t_read_en = 1'b0; i_err = 1'b1; i_ack = 1'b1; i_dat_r = 32'hCAFEF00D;
        tick();
        i_err = 1'b0; i_ack = 1'b0;
        check("rerr_valid", t_read_valid, 1);
        check("rerr_data", t_read_data, 0);
        check("rerr_flag", t_error, 1);
        check("rerr_addr", t_error_addr, 32'h300);
        tick();

        // Write 0x400 with error keeps first error address
        t_addr = 32'h400; t_write_en = 1'b1; t_byte_en = 4'hF;
        tick();
        t_write_en = 1'b0; i_err = 1'b1;
        tick();
        i_err = 1'b0;
        check("werr_novalid", t_read_valid, 0);
        check("werr_addr_kept", {t_error, t_error_addr}, {1'b1, 32'h300});
        tick();
        t_error_clr = 1'b1;
        tick();
        t_error_clr = 1'b0;
        check("err_clr", t_error, 0);
        check("err_addr_after_clr", t_error_addr, 32'h300);

        // Error set with simultaneous clear: set wins and new address latches
        t_addr = 32'h600; t_read_en = 1'b1;
        tick();
        t_read_en = 1'b0; i_err = 1'b1; t_error_clr = 1'b1;
        tick();
        i_err = 1'b0; t_error_clr = 1'b0;
        check("set_wins", {t_error, t_error_addr}, {1'b1, 32'h600});
        tick();
        t_error_clr = 1'b1;
        tick();
        t_error_clr = 1'b0;
        check("err_clr2", t_error, 0);

        // Read and write together: write wins
        t_addr = 32'h500; t_read_en = 1'b1; t_write_en = 1'b1; t_byte_en = 4'hA; t_write_data = 32'hA5A5_0F0F;
        tick();
        t_read_en = 1'b0; t_write_en = 1'b0;
        check("rw_we", {i_cyc, i_we, i_sel}, {1'b1, 1'b1, 4'hA});
        check("rw_datw", i_dat_w, 32'hA5A5_0F0F);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("rw_novalid", {t_read_valid, i_cyc}, 0);
        tick();
        check("rw_single", {t_busy, i_cyc}, 0);

        // Reset in second BUS cycle aborts the cycle
        t_addr = 32'h700; t_read_en = 1'b1;
        tick();
        t_read_en = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("abort_cyc", {i_cyc, i_stb, t_busy}, 0);
        check("abort_flags", {t_read_valid, t_error}, 0);
        tick();
        reset = 1'b1; t_addr = 32'h800; t_read_en = 1'b1;
        tick();
        t_read_en = 1'b0;
        check("post_rst_accept", {i_cyc, i_adr}, {1'b1, 32'h800});
        i_ack = 1'b1; i_dat_r = 32'h0000_0800;
        tick();
        i_ack = 1'b0;
        check("post_rst_read", {t_read_valid, t_read_data}, {1'b1, 32'h800});
        tick();

        // Target never responds
        t_addr = 32'h900; t_read_en = 1'b1;
        tick();
        t_read_en = 1'b0;
`ifdef FW_SRAM_WB_INITIATOR_TIMEOUT_EN
        tick(); tick(); tick();
        check("wd_held4", i_cyc, 1);
        tick();
        check("wd_drop", {i_cyc, t_read_valid, t_error}, 3'b011);
        check("wd_data", {t_read_data, t_error_addr}, {32'h0, 32'h900});
        tick();
        check("wd_idle", t_busy, 0);
`else
        held = 0;
        for (int n = 0; n < 1000; n++) begin
            if (i_cyc === 1'b1) held++;
            tick();
        end
        check("nowd_held", held, 1000);
        check("nowd_still", {i_cyc, t_busy, t_error}, 3'b110);
        i_ack = 1'b1; i_dat_r = 32'h1234;
        tick();
        i_ack = 1'b0;
        check("nowd_done", {t_read_valid, t_read_data}, {1'b1, 32'h1234});
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
